// File: rtl/mips_fetch_pkg.sv
// Shared fetch-path defaults and the issue-source decode used by instruction_fetch.
// Instruction memory and decode import the same package so address widths agree.
package mips_fetch_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          ADDR_INC_DEF = 1;

  // Source of the address presented to memory this cycle, highest priority first.
  typedef enum logic [1:0] {
    SEL_REDIRECT = 2'd0,
    SEL_ISSUE    = 2'd1,
    SEL_IDLE     = 2'd2,
    SEL_STALL    = 2'd3
  } fetch_sel_e;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Transfer and stall event counters for the fetch stage; both wrap modulo 2^32.
// Instantiated by instruction_fetch only when FETCH_PERF_EN is defined.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        xfer_i,
  input  logic        stall_i,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    fetched_d = fetched_q + {31'd0, xfer_i};
    stall_d   = stall_q + {31'd0, stall_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched_o = fetched_q;
  assign perf_stall_o   = stall_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction memory and hands {inst, pc} to decode.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counter outputs.
module instruction_fetch
  import mips_fetch_pkg::*;
#(
  parameter int               ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int               ADDR_INC = ADDR_INC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              advance;
  fetch_sel_e        sel;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(ADDR_INC);
  endfunction

  assign advance = inst_ready | ~rsp_valid_q;

  always_comb begin
    sel = SEL_STALL;
    if (redirect_valid)            sel = SEL_REDIRECT;
    else if (advance && fetch_en)  sel = SEL_ISSUE;
    else if (advance)              sel = SEL_IDLE;
  end

  // Stall and idle re-read rsp_pc_q so imem_rdata keeps showing the held word.
  always_comb begin
    imem_addr   = rsp_pc_q;
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = rsp_valid_q;
    case (sel)
      SEL_REDIRECT: begin
        imem_addr   = redirect_pc;
        rsp_pc_d    = redirect_pc;
        rsp_valid_d = 1'b1;
        pc_d        = pc_inc(redirect_pc);
      end
      SEL_ISSUE: begin
        imem_addr   = pc_q;
        rsp_pc_d    = pc_q;
        rsp_valid_d = 1'b1;
        pc_d        = pc_inc(pc_q);
      end
      SEL_IDLE:  rsp_valid_d = 1'b0;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      rsp_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // A redirect squashes the word on imem_rdata in the same cycle.
  assign inst       = imem_rdata;
  assign inst_pc    = rsp_pc_q;
  assign inst_valid = rsp_valid_q & ~redirect_valid;

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .xfer_i         (inst_valid & inst_ready),
    .stall_i        (rsp_valid_q & ~inst_ready & ~redirect_valid),
    .perf_fetched_o (perf_fetched),
    .perf_stall_o   (perf_stall)
  );
`endif

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch-stage requester for the synchronous, word-addressed instruction memory. Owns the program counter and drives the memory read address every cycle. Pairs each returned word with its PC and hands the result to decode through a valid/ready handshake. Handles decode back-pressure, branch/jump redirects and fetch enable, and hides the memory's one-cycle read latency from decode.

## Interface
Parameters:
- ADDR_W, 32, width of PC and memory address
- RESET_PC, 32'h0, first address issued after reset
- ADDR_INC, 1, PC increment per instruction (memory is word-indexed)

Ports:
- clk  in  1  rising-edge clock, shared with instruction memory
- rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  permit issuing new addresses
- imem_addr  out  ADDR_W  read address to instruction memory; combinational
- imem_rdata  in  32  memory word for the address presented on the previous edge
- inst  out  32  instruction to decode (= imem_rdata)
- inst_pc  out  ADDR_W  address of inst
- inst_valid  out  1  inst/inst_pc valid
- inst_ready  in  1  decode accepts this cycle
- redirect_valid  in  1  branch/jump taken; one-cycle pulse or held
- redirect_pc  in  ADDR_W  redirect target

## Operation
- State: pc_q (next address to issue), rsp_pc_q (address whose data is on imem_rdata), rsp_valid_q.
- Outputs: inst = imem_rdata, inst_pc = rsp_pc_q, inst_valid = rsp_valid_q & !redirect_valid.
- advance = inst_ready | !rsp_valid_q.
- imem_addr priority:
  - redirect_valid → redirect_pc
  - advance & fetch_en → pc_q
  - otherwise → rsp_pc_q, re-reading the held word so imem_rdata stays stable under stall.
- On edge, same priority:
  - Redirect: rsp_pc_q ← redirect_pc, rsp_valid_q ← 1, pc_q ← redirect_pc + ADDR_INC. The word presented this cycle is squashed and never accepted.
  - Advance & fetch_en: rsp_pc_q ← pc_q, rsp_valid_q ← 1, pc_q ← pc_q + ADDR_INC.
  - Advance & !fetch_en: rsp_valid_q ← 0, pc_q held.
  - Stall (rsp_valid_q & !inst_ready): all state held.
- Redirect overrides stall and fetch_en.
- PC arithmetic is modulo 2^ADDR_W; 0xFFFFFFFF + 1 wraps to 0 silently.
- Transfer occurs when inst_valid & inst_ready at the edge.

## Timing
- Reset (async assert, sync release by the system):
  - pc_q = RESET_PC, rsp_pc_q = RESET_PC, rsp_valid_q = 0.
  - inst_valid = 0, inst_pc = RESET_PC.
  - imem_addr = RESET_PC if fetch_en, else RESET_PC via the hold path; same value either way.
- Latency: address issued in cycle N gives inst_valid in cycle N+1.
- Throughput: one instruction per cycle while inst_ready is held high.
- Redirect penalty: zero bubbles after the redirect cycle. The target word is valid in the next cycle.
- Combinational paths: inst_ready → imem_addr and redirect_valid → imem_addr/inst_valid. Decode must drive both from registers.
- Reset mid-stall or mid-redirect: state returns to reset values immediately; the in-flight word is discarded.

## Configuration
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetched (32, count of transfers) and perf_stall (32, cycles with rsp_valid_q & !inst_ready & !redirect_valid).
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and logic are absent; remaining behaviour is identical.

## Structure
- Shared package mips_fetch_pkg holds ADDR_W default, RESET_PC default and ADDR_INC. The instruction memory and decode use the same package.
- One sub-module: fetch_perf_ctr (the two counters), instantiated only under FETCH_PERF_EN.
- PC/response registers and the address mux live in instruction_fetch itself.

## Test plan
- Reset release, fetch_en=1, inst_ready=1, mem[k]=k+0x100:
  - Cycle 0 imem_addr=0.
  - Cycle 1 inst_valid=1, inst=0x100, inst_pc=0.
  - Cycle 2 inst=0x101, inst_pc=1.
- Stall with inst_ready=0 for 3 cycles while inst_pc=2: imem_addr=2 and inst=0x102 held all 3 cycles. After release, next inst_pc=3 with no duplicate and no skip.
- Redirect pulse with redirect_pc=0x20 while inst_pc=5:
  - Same cycle: inst_valid=0, imem_addr=0x20.
  - Next cycle: inst_pc=0x20, then 0x21.
- Redirect during stall with redirect_pc=0x40: redirect wins; next cycle inst_pc=0x40, and 5 is never transferred.
- fetch_en dropped after inst_pc=7 accepted: inst_valid=0 next cycle. fetch_en raised again: inst_pc=8 one cycle later.
- Wrap, RESET_PC=0xFFFFFFFF: inst_pc 0xFFFFFFFF then 0x00000000. With FETCH_PERF_EN, perf_fetched=2 and perf_stall=0.
